md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencer for the shared HI/LO multiply-divide resource in the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations from the E stage, using the HILOtype field carried by the E pipeline register.
- Models the fixed multi-cycle latency of multiply and divide, and owns the HI and LO registers.
- Produces the D-stage stall request for any instruction that touches HI/LO while the unit is occupied.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu, counted after the start edge; legal range 1..15.
- DIV_CYCLES, 10: busy cycles for div/divu, counted after the start edge; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Req  in  1  exception/interrupt flush; the E-stage op is being cancelled this cycle.
- HILOtype_E  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 treated as none.
- A_E  in  32  forwarded rs value.
- B_E  in  32  forwarded rt value.
- D_md  in  1  D-stage instruction is any HI/LO-type instruction.
- HILO_out  out  32  mfhi/mflo read data.
- Busy  out  1  a multiply/divide is in flight.
- Start  out  1  an E-stage mult/div is being accepted this cycle.
- Stall_md  out  1  stall request to the hazard unit.
- Stall_cnt  out  32  stall-cycle counter; see Optional Feature.

Behaviour:
- Reset (asynchronous, reset==0):
  - HI=0, LO=0, state=IDLE, counter=0.
  - Busy=0, Stall_cnt=0.
  - Start, Stall_md and HILO_out follow from the reset state, so Start=0, Stall_md=0, HILO_out=0.
  - Reset mid-operation abandons the operation; HI/LO are not written.
- Start (combinational) = state==IDLE & HILOtype_E in 1..4 & !Req.
- Stall_md (combinational) = D_md & (Busy | Start).
- HILO_out (combinational):
  - HI when HILOtype_E==5; LO when HILOtype_E==6; else 0.
  - Always shows the committed HI/LO values. No bypass is needed, because stalling guarantees no in-flight result.
- States:
  - IDLE:
    - On Start, compute the result from A_E/B_E and hold it in internal RES_HI/RES_LO.
    - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4), then go to BUSY.
    - On op 7 & !Req, HI<=A_E next edge. On op 8 & !Req, LO<=A_E next edge.
  - BUSY:
    - Busy=1 throughout.
    - Counter decrements each cycle.
    - On the edge where the counter goes from 1 to 0: HI/LO<=RES_HI/RES_LO, state goes to IDLE, Busy deasserts in the following cycle.
    - Any E-stage op arriving in BUSY is ignored, including mthi/mtlo. The hazard unit prevents this case.
    - Req in BUSY does not cancel the operation, because it is already committed.
- Result latency: a mult started at edge t writes HI/LO at edge t+MULT_CYCLES. A dependent mfhi leaves D at the earliest on the cycle after that write.
- Req and Start in the same cycle: the op is cancelled; there is no state change and no HI/LO write.
- Arithmetic:
  - mult: signed 64-bit product, HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product, same split.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divide by zero (div or divu): the full busy time elapses; HI/LO are left unchanged.

Optional Feature:
- Macro MD_PERF_EN.
- Defined: Stall_cnt increments by 1 (wrapping 0xFFFFFFFF to 0) on every rising edge where Stall_md==1. Reset clears it.
- Undefined: Stall_cnt is tied to 0 and no counter register exists.

Test Plan:
- Signed multiply and read-back:
  - Stimulus: mult A=0xFFFFFFFE (-2), B=3 accepted at edge t; mfhi/mflo presented in E after Busy falls.
  - Response: Busy=1 for 5 cycles; HI=0xFFFFFFFF and LO=0xFFFFFFFA written at edge t+5; HILO_out=0xFFFFFFFF then 0xFFFFFFFA.
- Unsigned divide with stalled dependent, plus divide by zero:
  - Stimulus: divu 17/5 with D_md=1 held throughout; then divu 7/0.
  - Response: Stall_md=1 on the start cycle and the 10 following cycles; HI=2, LO=3. After the divide by zero completes, HI/LO are still 2/3.
- Signed divide edge cases:
  - Stimulus: div -7/2, then div 0x80000000/0xFFFFFFFF.
  - Response: LO=0xFFFFFFFD, HI=0xFFFFFFFF for the first; LO=0x80000000, HI=0 for the second.
- Flush behaviour:
  - Stimulus: Req=1 in the cycle mult 4*4 is in E; separately, Req=1 two cycles into a running mult 4*4.
  - Response: the first gives Start=0 with HI/LO unchanged; the second completes with LO=16.
- mthi/mtlo and asynchronous reset:
  - Stimulus: mthi 0x1234, then mtlo 0x5678; later, reset pulsed low mid-BUSY between clock edges.
  - Response: HI=0x1234, LO=0x5678 on the following edges. On reset: Busy, HI and LO become 0 immediately without a clock edge, and no write follows.
- Stall counter:
  - Stimulus: with MD_PERF_EN defined, run a mult with D_md=1 held.
  - Response: Stall_cnt=6 afterward. Without the macro, Stall_cnt stays 0.

Source files
------------

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module      : md_sched
// Description : HI/LO multiply-divide sequencer for the 5-stage MIPS pipeline.
//               Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E
//               stage, models fixed multi-cycle latency, owns HI/LO and raises
//               the D-stage stall request while the unit is occupied.
//               Optional macro MD_PERF_EN adds a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  HILOtype_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        D_md,
  output logic [31:0] HILO_out,
  output logic        Busy,
  output logic        Start,
  output logic        Stall_md,
  output logic [31:0] Stall_cnt
);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MFHI  = 4'd5;
  localparam logic [3:0] c_OP_MFLO  = 4'd6;
  localparam logic [3:0] c_OP_MTHI  = 4'd7;
  localparam logic [3:0] c_OP_MTLO  = 4'd8;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [31:0] r_res_hi, w_res_hi_nxt;
  logic [31:0] r_res_lo, w_res_lo_nxt;
  logic        r_res_wr, w_res_wr_nxt;   // cleared for divide by zero

  logic        w_is_md_op;
  logic        w_start;
  logic        w_busy;
  logic        w_stall;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_den_u, w_q_u, w_r_u;
  logic [31:0] w_abs_a, w_abs_b, w_q_mag, w_r_mag, w_q_s, w_r_s;

  assign w_is_md_op = (HILOtype_E >= c_OP_MULT) && (HILOtype_E <= c_OP_DIVU);
  assign w_busy     = (r_state == S_BUSY);
  assign w_start    = (r_state == S_IDLE) && w_is_md_op && !Req;
  assign w_stall    = D_md && (w_busy || w_start);

  assign Busy     = w_busy;
  assign Start    = w_start;
  assign Stall_md = w_stall;
  assign HILO_out = (HILOtype_E == c_OP_MFHI) ? r_hi :
                    (HILOtype_E == c_OP_MFLO) ? r_lo : 32'd0;

  // Products: sign- or zero-extend to 64 bits, the low 64 bits are exact.
  assign w_prod_s = {{32{A_E[31]}}, A_E} * {{32{B_E[31]}}, B_E};
  assign w_prod_u = {32'd0, A_E} * {32'd0, B_E};

  // Unsigned divide; divisor forced non-zero so the datapath never sees /0.
  assign w_den_u = (B_E == 32'd0) ? 32'd1 : B_E;
  assign w_q_u   = A_E / w_den_u;
  assign w_r_u   = A_E % w_den_u;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  assign w_abs_a = A_E[31] ? (32'd0 - A_E) : A_E;
  assign w_abs_b = (B_E == 32'd0) ? 32'd1 : (B_E[31] ? (32'd0 - B_E) : B_E);
  assign w_q_mag = w_abs_a / w_abs_b;
  assign w_r_mag = w_abs_a % w_abs_b;
  assign w_q_s   = (A_E[31] ^ B_E[31]) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r_s   = A_E[31] ? (32'd0 - w_r_mag) : w_r_mag;

  // Next-state: accept ops in IDLE, count down and commit in BUSY.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_res_hi_nxt = r_res_hi;
    w_res_lo_nxt = r_res_lo;
    w_res_wr_nxt = r_res_wr;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt  = S_BUSY;
          w_res_wr_nxt = 1'b1;
          case (HILOtype_E)
            c_OP_MULT: begin
              w_cnt_nxt = 4'(MULT_CYCLES);
              {w_res_hi_nxt, w_res_lo_nxt} = w_prod_s;
            end
            c_OP_MULTU: begin
              w_cnt_nxt = 4'(MULT_CYCLES);
              {w_res_hi_nxt, w_res_lo_nxt} = w_prod_u;
            end
            c_OP_DIV: begin
              w_cnt_nxt    = 4'(DIV_CYCLES);
              w_res_hi_nxt = w_r_s;
              w_res_lo_nxt = w_q_s;
              w_res_wr_nxt = (B_E != 32'd0);
            end
            default: begin
              w_cnt_nxt    = 4'(DIV_CYCLES);
              w_res_hi_nxt = w_r_u;
              w_res_lo_nxt = w_q_u;
              w_res_wr_nxt = (B_E != 32'd0);
            end
          endcase
        end else if (!Req && HILOtype_E == c_OP_MTHI) begin
          w_hi_nxt = A_E;
        end else if (!Req && HILOtype_E == c_OP_MTLO) begin
          w_lo_nxt = A_E;
        end
      end
      default: begin
        // Committed operation: E-stage ops and Req are ignored here.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_IDLE;
          if (r_res_wr) begin
            w_hi_nxt = r_res_hi;
            w_lo_nxt = r_res_lo;
          end
        end
      end
    endcase
  end

  // State register; asynchronous reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_res_wr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_res_hi <= w_res_hi_nxt;
      r_res_lo <= w_res_lo_nxt;
      r_res_wr <= w_res_wr_nxt;
    end
  end

`ifdef MD_PERF_EN
  logic [31:0] r_stall_cnt;

  // Count every edge on which the D stage is held by this unit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign Stall_cnt = r_stall_cnt;
`else
  assign Stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_sched
// Description : Self-checking bench for md_sched: directed vector table,
//               hand-written flush/reset/stall sequences and randomized ops
//               against a behavioural HI/LO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [3:0]  HILOtype_E;
  logic [31:0] A_E, B_E;
  logic        D_md;
  logic [31:0] HILO_out;
  logic        Busy, Start, Stall_md;
  logic [31:0] Stall_cnt;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Req(Req), .HILOtype_E(HILOtype_E),
    .A_E(A_E), .B_E(B_E), .D_md(D_md), .HILO_out(HILO_out),
    .Busy(Busy), .Start(Start), .Stall_md(Stall_md), .Stall_cnt(Stall_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_scnt = 32'd0;

  // Inputs driven while the unit is busy (must be ignored by the DUT)
  logic [3:0]  bsy_op  = 4'd0;
  logic [31:0] bsy_a   = 32'd0;
  logic        bsy_req = 1'b0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        dmd;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tv[10];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endfunction

  function automatic logic [31:0] exp_scnt();
`ifdef MD_PERF_EN
    return m_scnt;
`else
    return 32'd0;
`endif
  endfunction

  // Architectural result of an op, from 64-bit integer arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic wr, output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1; hi = 32'd0; lo = 32'd0;
    case (op)
      4'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      4'd2: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; end
      4'd3: if (b == 32'd0) wr = 1'b0;
            else begin q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r); end
      4'd4: if (b == 32'd0) wr = 1'b0;
            else begin lo = a / b; hi = a % b; end
      default: wr = 1'b0;
    endcase
  endfunction

  // Present one E-stage op for one cycle (called at posedge+1), then, if it
  // started a mult/div, drive the busy-phase inputs until Busy falls.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req, input logic dmd);
    logic        exp_start, wr;
    logic [31:0] exp_out, rh, rl;
    int          lat, n, n_st;
    HILOtype_E = op; A_E = a; B_E = b; Req = req; D_md = dmd;
    @(negedge clk);
    exp_start = (op >= 4'd1) && (op <= 4'd4) && !req;
    exp_out   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    chk("start", 32'(Start), 32'(exp_start));
    chk("hilo_out", HILO_out, exp_out);
    chk("stall_md_issue", 32'(Stall_md), 32'(dmd & exp_start));
    chk("busy_idle", 32'(Busy), 32'd0);
    @(posedge clk); #1;
    if (dmd && exp_start) m_scnt++;
    if (!req && op == 4'd7) m_hi = a;
    if (!req && op == 4'd8) m_lo = a;
    HILOtype_E = 4'd0; Req = 1'b0;
    if (exp_start) begin
      ref_op(op, a, b, wr, rh, rl);
      lat = (op <= 4'd2) ? MULT_N : DIV_N;
      HILOtype_E = bsy_op; A_E = bsy_a; Req = bsy_req;
      n = 0; n_st = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (!Busy) break;
        n++;
        if (Stall_md) n_st++;
        @(posedge clk); #1;
      end
      HILOtype_E = 4'd0; Req = 1'b0; D_md = 1'b0;
      @(posedge clk); #1;
      chk("busy_cycles", 32'(n), 32'(lat));
      chk("stall_cycles", 32'(n_st), dmd ? 32'(lat) : 32'd0);
      if (dmd) m_scnt += 32'(lat);
      if (wr) begin m_hi = rh; m_lo = rl; end
    end
    D_md = 1'b0;
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;

    tv[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tv[1] = '{4'd4, 32'd17,       32'd5,        1'b1, 32'd2,        32'd3};
    tv[2] = '{4'd4, 32'd7,        32'd0,        1'b0, 32'd2,        32'd3};
    tv[3] = '{4'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000};
    tv[5] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    tv[6] = '{4'd7, 32'h1234,     32'd0,        1'b0, 32'h1234,     32'h00000001};
    tv[7] = '{4'd8, 32'h5678,     32'd0,        1'b0, 32'h1234,     32'h5678};
    tv[8] = '{4'd1, 32'd4,        32'd4,        1'b0, 32'd0,        32'd16};
    tv[9] = '{4'd1, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'd0};

    reset = 1'b0; Req = 1'b0; HILOtype_E = 4'd5; A_E = 32'd0; B_E = 32'd0; D_md = 1'b1;
    #12;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_start", 32'(Start), 32'd0);
    chk("rst_stall_md", 32'(Stall_md), 32'd0);
    chk("rst_hilo_out", HILO_out, 32'd0);
    chk("rst_stall_cnt", Stall_cnt, 32'd0);
    HILOtype_E = 4'd0; D_md = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      issue(tv[i].op, tv[i].a, tv[i].b, 1'b0, tv[i].dmd);
      HILOtype_E = 4'd5; #1;
      chk("tbl_hi", HILO_out, tv[i].exp_hi);
      HILOtype_E = 4'd6; #1;
      chk("tbl_lo", HILO_out, tv[i].exp_lo);
      HILOtype_E = 4'd0;
    end
    chk("stall_cnt_tbl", Stall_cnt, exp_scnt());

    // Flush in the issue cycle: no start, no busy, HI/LO unchanged
    issue(4'd1, 32'd4, 32'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_busy", 32'(Busy), 32'd0);
    @(posedge clk); #1;
    issue(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);

    // Req and a stray mthi during BUSY neither cancel nor write
    issue(4'd7, 32'hAAAA0000, 32'd0, 1'b0, 1'b0);
    bsy_op = 4'd7; bsy_a = 32'hDEAD; bsy_req = 1'b1;
    issue(4'd1, 32'd4, 32'd4, 1'b0, 1'b0);
    bsy_op = 4'd0; bsy_a = 32'd0; bsy_req = 1'b0;
    HILOtype_E = 4'd6; #1; chk("req_busy_lo", HILO_out, 32'd16);
    HILOtype_E = 4'd5; #1; chk("req_busy_hi", HILO_out, 32'd0);
    HILOtype_E = 4'd0;

    // mthi/mtlo, then asynchronous reset in the middle of a multiply
    issue(4'd7, 32'h1234, 32'd0, 1'b0, 1'b0);
    issue(4'd8, 32'h5678, 32'd0, 1'b0, 1'b0);
    HILOtype_E = 4'd1; A_E = 32'd7; B_E = 32'd9;
    @(posedge clk); #1;
    HILOtype_E = 4'd5;
    @(posedge clk); #2;
    chk("pre_rst_busy", 32'(Busy), 32'd1);
    chk("pre_rst_hi", HILO_out, 32'h1234);
    reset = 1'b0; #1;
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_hi", HILO_out, 32'd0);
    HILOtype_E = 4'd6; #1;
    chk("arst_lo", HILO_out, 32'd0);
    chk("arst_stall_cnt", Stall_cnt, 32'd0);
    HILOtype_E = 4'd0;
    m_hi = 32'd0; m_lo = 32'd0; m_scnt = 32'd0;
    @(posedge clk); @(negedge clk); reset = 1'b1;
    repeat (MULT_N + 3) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(Busy), 32'd0);
    issue(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);

    // Stall counter with a dependent held in D during a multiply
    issue(4'd1, 32'd3, 32'd5, 1'b0, 1'b1);
    chk("stall_cnt_mult", Stall_cnt, exp_scnt());

    // Randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 7));
        2:       r_b = 32'hFFFFFFFF;
        default: r_b = $urandom;
      endcase
      bsy_op  = 4'($urandom_range(0, 15));
      bsy_a   = $urandom;
      bsy_req = 1'($urandom_range(0, 1));
      issue(r_op, r_a, r_b, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end
    bsy_op = 4'd0; bsy_req = 1'b0;
    issue(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stall_cnt_final", Stall_cnt, exp_scnt());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
